// File: rtl/ahb_rf_dbg_pkg.sv
// rtl/ahb_rf_dbg_pkg.sv - shared AHB-Lite constants (package ahb_defs)
package ahb_defs;

    localparam logic [1:0] HTRANS_IDLE   = 2'b00;
    localparam logic [1:0] HTRANS_BUSY   = 2'b01;
    localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
    localparam logic [1:0] HTRANS_SEQ    = 2'b11;

    localparam logic       HRESP_OKAY    = 1'b0;
    localparam logic       HRESP_ERROR   = 1'b1;

    localparam logic [2:0] SIZE_WORD     = 3'b010;

    localparam logic [7:0] CNT_OFFSET    = 8'h80;

endpackage

// File: rtl/ahb_rf_dbg_if.sv
// rtl/ahb_rf_dbg_if.sv - AHB-Lite slave bus plus register-file debug read port bundle
interface ahb_rf_dbg_if;

    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;
    logic        hready;
    logic        hreadyout;
    logic        hresp;
    logic [31:0] hrdata;
    logic [4:0]  ahb_rf_addr;
    logic [31:0] ahb_rf_data;

    modport master (
        output hsel, haddr, htrans, hwrite, hsize, hready,
        input  hreadyout, hresp, hrdata
    );

    modport slave (
        input  hsel, haddr, htrans, hwrite, hsize, hready,
        output hreadyout, hresp, hrdata
    );

    modport rf (
        input  ahb_rf_addr,
        output ahb_rf_data
    );

endinterface

// File: rtl/ahb_rf_dbg.sv
// rtl/ahb_rf_dbg.sv - AHB-Lite read-only debug window onto a register file plus completed-read counter
module ahb_rf_dbg
    import ahb_defs::*;
#(
    parameter int CNT_W = 16
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        hsel,
    input  logic [31:0] haddr,
    input  logic [1:0]  htrans,
    input  logic        hwrite,
    input  logic [2:0]  hsize,
    input  logic        hready,
    output logic        hreadyout,
    output logic        hresp,
    output logic [31:0] hrdata,
    output logic [4:0]  ahb_rf_addr,
    input  logic [31:0] ahb_rf_data
);

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_READ = 3'd1,
        ST_RESP = 3'd2,
        ST_ERR1 = 3'd3,
        ST_ERR2 = 3'd4
    } state_t;

    state_t             state;
    logic               sel_cnt;
    logic [CNT_W-1:0]   rd_cnt;

    logic take;
    logic legal;

    // Only evaluated from IDLE/RESP/ERR2; READ and ERR1 ignore the address phase.
    assign take  = hsel && htrans[1] && hready;
    assign legal = !hwrite && (hsize == SIZE_WORD) && (haddr[1:0] == 2'b00) &&
                   (!haddr[7] || (haddr[7:0] == CNT_OFFSET));

    logic unused_ok;
    assign unused_ok = &{1'b0, haddr[31:8], htrans[0]};

    always_ff @(posedge clk) begin
        if (!rstn) begin
            state       <= ST_IDLE;
            hreadyout   <= 1'b1;
            hresp       <= HRESP_OKAY;
            hrdata      <= 32'd0;
            ahb_rf_addr <= 5'd0;
            sel_cnt     <= 1'b0;
            rd_cnt      <= '0;
        end else begin
            case (state)
                ST_READ: begin
                    // Counter reads report the value before this read is counted.
                    hrdata    <= sel_cnt ? 32'(rd_cnt) : ahb_rf_data;
                    rd_cnt    <= rd_cnt + CNT_W'(1);
                    state     <= ST_RESP;
                    hreadyout <= 1'b1;
                    hresp     <= HRESP_OKAY;
                end
                ST_ERR1: begin
                    state     <= ST_ERR2;
                    hreadyout <= 1'b1;
                    hresp     <= HRESP_ERROR;
                end
                default: begin
                    if (take && legal) begin
                        state       <= ST_READ;
                        hreadyout   <= 1'b0;
                        hresp       <= HRESP_OKAY;
                        ahb_rf_addr <= haddr[6:2];
                        sel_cnt     <= haddr[7];
                    end else if (take) begin
                        state     <= ST_ERR1;
                        hreadyout <= 1'b0;
                        hresp     <= HRESP_ERROR;
                    end else begin
                        state     <= ST_IDLE;
                        hreadyout <= 1'b1;
                        hresp     <= HRESP_OKAY;
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_ahb_rf_dbg.sv
// tb/tb_ahb_rf_dbg.sv - bench for ahb_rf_dbg (CNT_W=16 and CNT_W=2 instances driven in lockstep)
module tb_ahb_rf_dbg;
    import ahb_defs::*;

    localparam logic [1:0] K_OK  = 2'd0;
    localparam logic [1:0] K_RD  = 2'd1;
    localparam logic [1:0] K_ERR = 2'd2;

    typedef struct {
        logic        sel;
        logic [1:0]  trans;
        logic        wr;
        logic [2:0]  size;
        logic [31:0] addr;
        logic [1:0]  kind;
        logic [31:0] exp_a;
        logic [31:0] exp_b;
        logic [4:0]  exp_idx;
    } vec_t;

    logic        clk = 1'b0;
    logic        rstn;
    logic        hsel;
    logic [31:0] haddr;
    logic [1:0]  htrans;
    logic        hwrite;
    logic [2:0]  hsize;

    int n_cmp = 0;
    int n_bad = 0;

    int unsigned cnt_reads;
    logic [31:0] last_a, last_b;
    logic [4:0]  last_idx;

    ahb_rf_dbg_if bus_a();
    ahb_rf_dbg_if bus_b();

    assign bus_a.hsel   = hsel;   assign bus_b.hsel   = hsel;
    assign bus_a.haddr  = haddr;  assign bus_b.haddr  = haddr;
    assign bus_a.htrans = htrans; assign bus_b.htrans = htrans;
    assign bus_a.hwrite = hwrite; assign bus_b.hwrite = hwrite;
    assign bus_a.hsize  = hsize;  assign bus_b.hsize  = hsize;
    assign bus_a.hready = bus_a.hreadyout;
    assign bus_b.hready = bus_a.hreadyout;
    assign bus_a.ahb_rf_data = 32'hDEAD_0000 + {27'd0, bus_a.ahb_rf_addr};
    assign bus_b.ahb_rf_data = 32'hDEAD_0000 + {27'd0, bus_b.ahb_rf_addr};

    ahb_rf_dbg #(.CNT_W(16)) dut_a (
        .clk(clk), .rstn(rstn),
        .hsel(bus_a.hsel), .haddr(bus_a.haddr), .htrans(bus_a.htrans),
        .hwrite(bus_a.hwrite), .hsize(bus_a.hsize), .hready(bus_a.hready),
        .hreadyout(bus_a.hreadyout), .hresp(bus_a.hresp), .hrdata(bus_a.hrdata),
        .ahb_rf_addr(bus_a.ahb_rf_addr), .ahb_rf_data(bus_a.ahb_rf_data)
    );

    ahb_rf_dbg #(.CNT_W(2)) dut_b (
        .clk(clk), .rstn(rstn),
        .hsel(bus_b.hsel), .haddr(bus_b.haddr), .htrans(bus_b.htrans),
        .hwrite(bus_b.hwrite), .hsize(bus_b.hsize), .hready(bus_b.hready),
        .hreadyout(bus_b.hreadyout), .hresp(bus_b.hresp), .hrdata(bus_b.hrdata),
        .ahb_rf_addr(bus_b.ahb_rf_addr), .ahb_rf_data(bus_b.ahb_rf_data)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input vec_t v);
        hsel   = v.sel;
        htrans = v.trans;
        hwrite = v.wr;
        hsize  = v.size;
        haddr  = v.addr;
    endtask

    task automatic drive_idle();
        hsel   = 1'b0;
        htrans = HTRANS_IDLE;
        hwrite = 1'b0;
        hsize  = SIZE_WORD;
        haddr  = 32'd0;
    endtask

    task automatic drive_junk();
        hsel   = 1'b1;
        htrans = HTRANS_NONSEQ;
        hwrite = 1'($urandom_range(0, 1));
        hsize  = 3'($urandom_range(0, 7));
        haddr  = $urandom;
    endtask

    function automatic vec_t mk(input logic sel, input logic [1:0] trans, input logic wr,
                                input logic [2:0] size, input logic [31:0] addr);
        vec_t r;
        r.sel = sel; r.trans = trans; r.wr = wr; r.size = size; r.addr = addr;
        r.kind = K_OK; r.exp_a = 32'd0; r.exp_b = 32'd0; r.exp_idx = 5'd0;
        return r;
    endfunction

    // Reference: decides the response class and data of a transfer from the address map rules.
    function automatic vec_t model(input vec_t v);
        vec_t r;
        int unsigned off;
        r = v;
        off = v.addr % 256;
        r.exp_a = 32'd0; r.exp_b = 32'd0; r.exp_idx = 5'd0;
        if (!(v.sel && (v.trans == HTRANS_NONSEQ || v.trans == HTRANS_SEQ))) begin
            r.kind = K_OK;
        end else if (!v.wr && v.size == 3'd2 && (off % 4) == 0 && (off <= 124 || off == 128)) begin
            r.kind = K_RD;
            if (off == 128) begin
                r.exp_a   = cnt_reads % 65536;
                r.exp_b   = cnt_reads % 4;
                r.exp_idx = 5'd0;
            end else begin
                r.exp_a   = 32'hDEAD_0000 + off / 4;
                r.exp_b   = r.exp_a;
                r.exp_idx = 5'(off / 4);
            end
            cnt_reads++;
        end else begin
            r.kind = K_ERR;
        end
        return r;
    endfunction

    // Issues the list back-to-back: each next address phase overlaps the final response cycle.
    task automatic run(input vec_t v[$]);
        drive(v[0]);
        @(posedge clk);
        for (int i = 0; i < v.size(); i++) begin
            @(negedge clk);
            if (v[i].kind != K_OK) begin
                chk($sformatf("v%0d wait_hreadyout", i), 32'(bus_a.hreadyout), 32'd0);
                chk($sformatf("v%0d wait_hresp", i), 32'(bus_a.hresp), 32'(v[i].kind == K_ERR));
                chk($sformatf("v%0d wait_rf_addr", i), 32'(bus_a.ahb_rf_addr),
                    32'(v[i].kind == K_RD ? v[i].exp_idx : last_idx));
                chk($sformatf("v%0d wait_hrdata", i), bus_a.hrdata, last_a);
                drive_junk();
                @(posedge clk);
                @(negedge clk);
                chk($sformatf("v%0d resp_hreadyout", i), 32'(bus_a.hreadyout), 32'd1);
                chk($sformatf("v%0d resp_hresp", i), 32'(bus_a.hresp), 32'(v[i].kind == K_ERR));
                if (v[i].kind == K_RD) begin
                    last_a   = v[i].exp_a;
                    last_b   = v[i].exp_b;
                    last_idx = v[i].exp_idx;
                end
                chk($sformatf("v%0d hrdata_w16", i), bus_a.hrdata, last_a);
                chk($sformatf("v%0d hrdata_w2", i), bus_b.hrdata, last_b);
                chk($sformatf("v%0d resp_rf_addr", i), 32'(bus_a.ahb_rf_addr), 32'(last_idx));
            end else begin
                chk($sformatf("v%0d ok_hreadyout", i), 32'(bus_a.hreadyout), 32'd1);
                chk($sformatf("v%0d ok_hresp", i), 32'(bus_a.hresp), 32'd0);
                chk($sformatf("v%0d ok_rf_addr", i), 32'(bus_a.ahb_rf_addr), 32'(last_idx));
                chk($sformatf("v%0d ok_hrdata", i), bus_a.hrdata, last_a);
            end
            if (i + 1 < v.size()) drive(v[i + 1]);
            else drive_idle();
            @(posedge clk);
        end
        @(negedge clk);
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        drive_idle();
        repeat (3) @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        cnt_reads = 0;
        last_a = 32'd0; last_b = 32'd0; last_idx = 5'd0;
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_hreadyout"}, 32'(bus_a.hreadyout), 32'd1);
        chk({tag, "_hresp"}, 32'(bus_a.hresp), 32'd0);
        chk({tag, "_hrdata"}, bus_a.hrdata, 32'd0);
        chk({tag, "_rf_addr"}, 32'(bus_a.ahb_rf_addr), 32'd0);
        chk({tag, "_hrdata_w2"}, bus_b.hrdata, 32'd0);
    endtask

    initial begin
        vec_t tbl[$];
        vec_t rnd[$];
        vec_t one[$];
        vec_t t;

        do_reset();
        chk_reset_state("reset");

        // Directed table with hand-derived expectations, run back-to-back from reset.
        t = mk(1, HTRANS_NONSEQ, 0, 3'b010, 32'h14); t.kind = K_RD; t.exp_a = 32'hDEAD_0005; t.exp_b = 32'hDEAD_0005; t.exp_idx = 5; tbl.push_back(t);
        t = mk(1, HTRANS_NONSEQ, 0, 3'b010, 32'h00); t.kind = K_RD; t.exp_a = 32'hDEAD_0000; t.exp_b = 32'hDEAD_0000; t.exp_idx = 0; tbl.push_back(t);
        t = mk(1, HTRANS_NONSEQ, 0, 3'b010, 32'h7C); t.kind = K_RD; t.exp_a = 32'hDEAD_001F; t.exp_b = 32'hDEAD_001F; t.exp_idx = 31; tbl.push_back(t);
        t = mk(1, HTRANS_NONSEQ, 1, 3'b010, 32'h08); t.kind = K_ERR; tbl.push_back(t);
        t = mk(1, HTRANS_NONSEQ, 0, 3'b010, 32'h09); t.kind = K_ERR; tbl.push_back(t);
        t = mk(1, HTRANS_NONSEQ, 0, 3'b001, 32'h08); t.kind = K_ERR; tbl.push_back(t);
        t = mk(1, HTRANS_NONSEQ, 0, 3'b010, 32'h84); t.kind = K_ERR; tbl.push_back(t);
        t = mk(1, HTRANS_NONSEQ, 0, 3'b010, 32'h80); t.kind = K_RD; t.exp_a = 32'd3; t.exp_b = 32'd3; t.exp_idx = 0; tbl.push_back(t);
        t = mk(1, HTRANS_SEQ,    0, 3'b010, 32'h80); t.kind = K_RD; t.exp_a = 32'd4; t.exp_b = 32'd0; t.exp_idx = 0; tbl.push_back(t);
        t = mk(1, HTRANS_BUSY,   0, 3'b010, 32'h10); t.kind = K_OK; tbl.push_back(t);
        t = mk(1, HTRANS_IDLE,   0, 3'b010, 32'h18); t.kind = K_OK; tbl.push_back(t);
        t = mk(0, HTRANS_NONSEQ, 0, 3'b010, 32'h1C); t.kind = K_OK; tbl.push_back(t);
        t = mk(1, HTRANS_NONSEQ, 0, 3'b010, 32'hFFFF_FF80); t.kind = K_RD; t.exp_a = 32'd5; t.exp_b = 32'd1; t.exp_idx = 0; tbl.push_back(t);
        run(tbl);

        // Reset while the FSM sits in READ aborts the capture and the count.
        one.delete();
        drive(mk(1, HTRANS_NONSEQ, 0, 3'b010, 32'h14));
        @(posedge clk);
        @(negedge clk);
        chk("pre_rst_hreadyout", 32'(bus_a.hreadyout), 32'd0);
        rstn = 1'b0;
        drive_idle();
        @(posedge clk);
        @(negedge clk);
        rstn = 1'b1;
        chk_reset_state("midrst");
        cnt_reads = 0;
        last_a = 32'd0; last_b = 32'd0; last_idx = 5'd0;
        one.push_back(model(mk(1, HTRANS_NONSEQ, 0, 3'b010, 32'h80)));
        run(one);

        // Randomized traffic against the reference model.
        do_reset();
        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            logic [2:0]  sz;
            a = $urandom;
            if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
            if ($urandom_range(0, 5) == 0) a[7:0] = 8'h80;
            sz = ($urandom_range(0, 4) == 0) ? 3'($urandom_range(0, 7)) : 3'b010;
            rnd.push_back(model(mk(1'($urandom_range(0, 9) != 0), 2'($urandom_range(0, 3)),
                                   1'($urandom_range(0, 4) == 0), sz, a)));
        end
        run(rnd);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
